// File: rtl/adc_sample_controller.sv
`default_nettype none
// ============================================================================
// Module  : adc_sample_controller
// Brief   : APB3 slave that triggers an ADC, collects results in a FIFO and
//           raises a level interrupt on data, overflow or timeout.
// Revision: 1.0 - initial release
// ============================================================================
module adc_sample_controller #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TRIG_CYCLES = 2,
  parameter int TIMEOUT     = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [11:0]           PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] ADC_TRIGGER,
  input  logic [DATA_WIDTH-1:0] MEASUREMENT,
  input  logic                  ADC_DONE,
  output logic                  IRQ
);

  localparam int C_AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int C_CW  = C_AW + 1;
  localparam int C_TCW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
  localparam int C_WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [C_CW-1:0]  C_DEPTH = C_CW'(FIFO_DEPTH);
  localparam logic [C_TCW-1:0] C_TLAST = C_TCW'(TRIG_CYCLES - 1);
  localparam logic [C_WCW-1:0] C_WLAST = C_WCW'(TIMEOUT - 1);

  localparam logic [2:0] C_A_CTRL   = 3'd0;
  localparam logic [2:0] C_A_PERIOD = 3'd1;
  localparam logic [2:0] C_A_STATUS = 3'd2;
  localparam logic [2:0] C_A_DATA   = 3'd3;
  localparam logic [2:0] C_A_CMD    = 3'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TRIG = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // Control / status registers
  logic                  r_en;
  logic                  r_cont;
  logic                  r_irq_en;
  logic [15:0]           r_period;
  logic                  r_ovf;
  logic                  r_tmo;
  logic [1:0]            r_state;
  logic [C_TCW-1:0]      r_tcnt;
  logic [C_WCW-1:0]      r_wcnt;
  logic [15:0]           r_ptmr;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_irq;
  logic                  r_pop_ok;

  // Result FIFO
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [C_AW-1:0]       r_wptr;
  logic [C_AW-1:0]       r_rptr;
  logic [C_CW-1:0]       r_count;

  logic [2:0]            w_addr;
  logic                  w_wr;
  logic                  w_rd_setup;
  logic                  w_rd_acc;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_busy;
  logic [15:0]           w_per_m1;
  logic                  w_tmr_run;
  logic                  w_tick;
  logic                  w_cmd_start;
  logic                  w_start;
  logic                  w_capture;
  logic                  w_timeout;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sts_wr;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  assign w_addr     = PADDR[4:2];
  assign w_wr       = PSEL & PENABLE & PWRITE;
  assign w_rd_setup = PSEL & ~PENABLE & ~PWRITE;
  assign w_rd_acc   = PSEL & PENABLE & ~PWRITE;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_busy  = (r_state != S_IDLE);

  // A programmed period of 0 behaves like 1
  assign w_per_m1  = (r_period == 16'd0) ? 16'd0 : (r_period - 16'd1);
  assign w_tmr_run = r_en & r_cont;
  assign w_tick    = w_tmr_run & (r_ptmr >= w_per_m1);

  assign w_cmd_start = w_wr & (w_addr == C_A_CMD) & PWDATA[0] & r_en;
  assign w_start     = (r_state == S_IDLE) & (w_cmd_start | w_tick);

  assign w_capture = r_en & (r_state == S_WAIT) & ADC_DONE;
  assign w_timeout = r_en & (r_state == S_WAIT) & ~ADC_DONE & (r_wcnt == C_WLAST);

  assign w_push   = w_capture & ~w_full;
  assign w_pop    = w_rd_acc & (w_addr == C_A_DATA) & r_pop_ok;
  assign w_sts_wr = w_wr & (w_addr == C_A_STATUS);

  assign w_unused = ^{PADDR[11:5], PADDR[1:0], PWDATA[DATA_WIDTH-1:16]};

  // Register write port
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_en     <= 1'b0;
      r_cont   <= 1'b0;
      r_irq_en <= 1'b0;
      r_period <= 16'd0;
    end else if (w_wr) begin
      if (w_addr == C_A_CTRL) begin
        r_en     <= PWDATA[0];
        r_cont   <= PWDATA[1];
        r_irq_en <= PWDATA[2];
      end
      if (w_addr == C_A_PERIOD) begin
        r_period <= PWDATA[15:0];
      end
    end
  end

  // Sticky flags: a new event in the same cycle wins over the W1C clear
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ovf <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~(w_sts_wr & PWDATA[2])) | (w_capture & w_full);
      r_tmo <= (r_tmo & ~(w_sts_wr & PWDATA[4])) | w_timeout;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ptmr <= 16'd0;
    end else if (!w_tmr_run || w_tick) begin
      r_ptmr <= 16'd0;
    end else begin
      r_ptmr <= r_ptmr + 16'd1;
    end
  end

  // Conversion sequencer; losing EN aborts from any state
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_wcnt  <= '0;
    end else if (!r_en) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_wcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_TRIG;
            r_tcnt  <= '0;
          end
        end
        S_TRIG: begin
          if (r_tcnt == C_TLAST) begin
            r_state <= S_WAIT;
            r_wcnt  <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (ADC_DONE || (r_wcnt == C_WLAST)) begin
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= MEASUREMENT;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_status           = '0;
    w_status[0]        = w_empty;
    w_status[1]        = w_full;
    w_status[2]        = r_ovf;
    w_status[3]        = w_busy;
    w_status[4]        = r_tmo;
    w_status[8 +: C_CW] = r_count;
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      C_A_CTRL:   w_rdata[2:0]  = {r_irq_en, r_cont, r_en};
      C_A_PERIOD: w_rdata[15:0] = r_period;
      C_A_STATUS: w_rdata       = w_status;
      C_A_DATA:   w_rdata       = w_empty ? '0 : r_mem[r_rptr];
      default:    w_rdata       = '0;
    endcase
  end

  // Read data is captured in the setup phase; the pop is committed in the
  // access phase only if the head was valid when it was sampled.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_prdata <= '0;
      r_pop_ok <= 1'b0;
    end else if (w_rd_setup) begin
      r_prdata <= w_rdata;
      r_pop_ok <= (w_addr == C_A_DATA) & ~w_empty;
    end else if (w_rd_acc) begin
      r_pop_ok <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & (~w_empty | r_ovf | r_tmo);
    end
  end

  assign PRDATA      = r_prdata;
  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign IRQ         = r_irq;
  assign ADC_TRIGGER = {{(DATA_WIDTH-1){1'b0}}, (r_state == S_TRIG) & r_en};

endmodule
`default_nettype wire

// File: doc/adc_sample_controller.md
Name: adc_sample_controller

Overview:
- APB3 slave peripheral that sits directly upstream of the ADC model and drives its ADC_TRIGGER input.
- Collects conversion results from the ADC's MEASUREMENT bus into a small FIFO for the CPU.
- Supports single-shot and periodic (timer-paced) conversions, with a conversion timeout, a sticky overflow flag and a level interrupt.

Parameters:
DATA_WIDTH, 32, width of APB data, MEASUREMENT and ADC_TRIGGER
FIFO_DEPTH, 4, result FIFO entries; power of two, 2..16
TRIG_CYCLES, 2, number of PCLK cycles ADC_TRIGGER[0] is held high per conversion
TIMEOUT, 256, maximum PCLK cycles waited for ADC_DONE after the trigger ends

Ports:
PCLK  in  1  system clock
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PADDR  in  12  byte address; [4:2] decoded
PWDATA  in  DATA_WIDTH  write data
PRDATA  out  DATA_WIDTH  read data
PREADY  out  1  tied 1
PSLVERR  out  1  tied 0
ADC_TRIGGER  out  DATA_WIDTH  bit0 = start pulse; upper bits 0
MEASUREMENT  in  DATA_WIDTH  conversion result; valid when ADC_DONE=1
ADC_DONE  in  1  one-cycle conversion-complete strobe
IRQ  out  1  level interrupt

Behaviour:
Reset and APB access
- Reset is asynchronous on PRESETn low. All registers, FIFO pointers and count are cleared; FSM goes to IDLE; ADC_TRIGGER=0, PRDATA=0, IRQ=0.
- A reset asserted mid-conversion aborts it immediately.
- Writes take effect in the access phase (PSEL&PENABLE&PWRITE).
- PRDATA is registered and valid in the access phase. Unmapped addresses read 0 and ignore writes.

Register map
- 0x00 CTRL, RW: [0] EN, [1] CONT, [2] IRQ_EN.
- 0x04 PERIOD, RW: [15:0] interval in PCLK cycles. 0 is treated as 1.
- 0x08 STATUS: [0] EMPTY (RO), [1] FULL (RO), [2] OVF (sticky, W1C), [3] BUSY (RO, FSM not IDLE), [4] TMO (sticky, W1C), [12:8] COUNT (RO).
- 0x0C DATA, RO: read returns the FIFO head and pops it. Reading while empty returns 0 with no pop and no pointer change.
- 0x10 CMD, WO: writing [0]=1 with EN=1 requests a single conversion. Ignored if EN=0. Ignored if BUSY, with no queuing.

FSM: IDLE -> TRIG -> WAIT -> IDLE
- IDLE: on a start request, go to TRIG next cycle.
  - Start request = CMD write, or a period tick while CONT=1.
- TRIG: ADC_TRIGGER[0]=1 for exactly TRIG_CYCLES cycles, then WAIT.
- WAIT: counter runs from 0. If ADC_DONE=1, capture MEASUREMENT and go to IDLE.
  - If the counter reaches TIMEOUT-1 with no ADC_DONE, set TMO, push nothing, go to IDLE.
- ADC_DONE outside WAIT is ignored.
- Clearing EN in any state returns the FSM to IDLE next cycle: ADC_TRIGGER drops, nothing is captured, FIFO contents are kept.

Period timer
- Runs only when EN=1 and CONT=1. Otherwise held at 0.
- Counts 0..PERIOD-1 and issues a tick on wrap.
- First tick occurs PERIOD cycles after CONT is set.
- A tick while BUSY is dropped; no backlog is kept.

FIFO
- Capture pushes when not full. Capture while full discards the sample, sets OVF and keeps the existing data.
- A push and a pop in the same cycle both occur; COUNT is unchanged.
- Pointers wrap modulo FIFO_DEPTH. COUNT ranges 0..FIFO_DEPTH.

Interrupt
- IRQ = IRQ_EN & (~EMPTY | OVF | TMO).
- Registered: updates one cycle after the cause.

Latency
- CMD write access cycle is N. TRIG is asserted N+1..N+TRIG_CYCLES.
- ADC_DONE in cycle M: data is readable and COUNT increments in cycle M+1.

Test Plan:
1. Single shot: CTRL=0x1; CMD=1; ADC_DONE with MEASUREMENT=0xA5A5_0123 three cycles after TRIG ends -> TRIG high exactly 2 cycles; STATUS COUNT=1, EMPTY=0; DATA read=0xA5A50123; then EMPTY=1 and a further DATA read returns 0.
2. Periodic: CTRL=0x3, PERIOD=20; ADC answers each trigger after 5 cycles -> triggers 20 cycles apart; after 4 conversions FULL=1; 5th sample sets OVF=1; FIFO reads return samples 1..4 in order.
3. Timeout: CTRL=0x5; CMD=1; ADC_DONE never asserted -> BUSY falls 2+256 cycles after the trigger starts; TMO=1, IRQ=1, COUNT=0; writing STATUS=0x10 clears TMO and IRQ.
4. Simultaneous: FIFO holds 3 entries and a DATA read coincides with the ADC_DONE capture -> COUNT stays 3; read returns the oldest entry; new sample is last in order.
5. Abort/reset: CMD=1, then clear EN during WAIT -> ADC_TRIGGER=0, IDLE, no push. Repeat with PRESETn pulsed low mid-TRIG -> all outputs 0 immediately and registers read 0 after release.
6. Ignored command: CMD=1 while BUSY, and CMD=1 with EN=0 -> exactly one conversion occurs, and none respectively.
